// File: rtl/pseudo_pll_nco.sv
// Phase-accumulator clock synthesiser: linear code -> increment, glitch-free retune at wrap.
// Optional build macro PSEUDO_PLL_PHASE_OUT_EN adds the registered phase_out[7:0] port.
module pseudo_pll_nco #(
   parameter int unsigned F_IN_HZ   = 1000000,
   parameter int unsigned F_OUT_MIN = 6000,
   parameter int unsigned F_OUT_MAX = 800000,
   parameter int unsigned CODE_W    = 8,
   parameter int unsigned ACC_W     = 24
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              run,
   input  logic              freq_load,
   input  logic [CODE_W-1:0] freq_param,
   output logic              freq_busy,
   output logic              update_done,
   output logic              clk_out,
   output logic              tick
`ifdef PSEUDO_PLL_PHASE_OUT_EN
   ,
   output logic [7:0]        phase_out
`endif
);

   localparam logic [63:0] INC_MIN  = (64'(F_OUT_MIN) << ACC_W) / 64'(F_IN_HZ);
   localparam logic [63:0] INC_MAX  = (64'(F_OUT_MAX) << ACC_W) / 64'(F_IN_HZ);
   localparam logic [63:0] INC_STEP = (INC_MAX - INC_MIN) / ((64'd1 << CODE_W) - 64'd1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [ACC_W-1:0] code_to_inc(input logic [CODE_W-1:0] code);
      return ACC_W'(INC_MIN + 64'(code) * INC_STEP);
   endfunction

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    inc_q, inc_d;
   logic [CODE_W-1:0]   pend_code_q, pend_code_d;
   logic                pend_flag_q, pend_flag_d;
   logic                clk_out_q, clk_out_d;
   logic                tick_q, tick_d;
   logic                done_q, done_d;
   logic [ACC_W:0]      acc_sum;
   logic                wrap;

   assign acc_sum = {1'b0, acc_q} + {1'b0, inc_q};
   assign wrap    = acc_sum[ACC_W];

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      inc_d       = inc_q;
      pend_code_d = pend_code_q;
      pend_flag_d = pend_flag_q;
      done_d      = 1'b0;
      clk_out_d   = acc_q[ACC_W-1];
      tick_d      = acc_q[ACC_W-1] & ~clk_out_q;

      case (state_q)
         ST_STOP: begin
            // Stopped: no period to protect, so a code takes effect at once.
            acc_d = '0;
            if (freq_load) begin
               inc_d       = code_to_inc(freq_param);
               pend_flag_d = 1'b0;
               done_d      = 1'b1;
            end else if (pend_flag_q) begin
               inc_d       = code_to_inc(pend_code_q);
               pend_flag_d = 1'b0;
               done_d      = 1'b1;
            end
            if (run) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN, ST_DRAIN: begin
            acc_d = acc_sum[ACC_W-1:0];
            if (wrap && pend_flag_q) begin
               inc_d       = code_to_inc(pend_code_q);
               pend_flag_d = 1'b0;
               done_d      = 1'b1;
            end
            // A load coincident with a wrap lands after the old code was applied.
            if (freq_load) begin
               pend_code_d = freq_param;
               pend_flag_d = 1'b1;
            end
            if (state_q == ST_RUN) begin
               if (!run) begin
                  state_d = ST_DRAIN;
               end
            end else if (run) begin
               state_d = ST_RUN;
            end else if (wrap) begin
               acc_d   = '0;
               state_d = ST_STOP;
            end
         end
         default: begin
            acc_d   = '0;
            state_d = ST_STOP;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= ST_STOP;
         acc_q       <= '0;
         inc_q       <= code_to_inc('0);
         pend_code_q <= '0;
         pend_flag_q <= 1'b0;
         clk_out_q   <= 1'b0;
         tick_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         inc_q       <= inc_d;
         pend_code_q <= pend_code_d;
         pend_flag_q <= pend_flag_d;
         clk_out_q   <= clk_out_d;
         tick_q      <= tick_d;
         done_q      <= done_d;
      end
   end

`ifdef PSEUDO_PLL_PHASE_OUT_EN
   logic [7:0] phase_q, phase_d;

   assign phase_d = acc_q[ACC_W-1 -: 8];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase_out = phase_q;
`endif

   assign freq_busy   = pend_flag_q;
   assign update_done = done_q;
   assign clk_out     = clk_out_q;
   assign tick        = tick_q;

endmodule

// File: tb/tb_pseudo_pll_nco.sv
// Directed bench for pseudo_pll_nco with a cycle-level phase model checked every cycle.
module tb_pseudo_pll_nco;

   localparam int     ACC_W  = 24;
   localparam longint F_IN   = 1000000;
   localparam longint F_MIN  = 6000;
   localparam longint F_MAX  = 800000;
   localparam longint MOD    = longint'(1) << ACC_W;
   localparam longint HALF   = MOD / 2;
   localparam longint M_INC_MIN  = F_MIN * MOD / F_IN;
   localparam longint M_INC_STEP = (F_MAX * MOD / F_IN - M_INC_MIN) / 255;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       run;
   logic       freq_load;
   logic [7:0] freq_param;
   logic       freq_busy;
   logic       update_done;
   logic       clk_out;
   logic       tick;
`ifdef PSEUDO_PLL_PHASE_OUT_EN
   logic [7:0] phase_out;
`endif

   pseudo_pll_nco dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .run         (run),
      .freq_load   (freq_load),
      .freq_param  (freq_param),
      .freq_busy   (freq_busy),
      .update_done (update_done),
      .clk_out     (clk_out),
      .tick        (tick)
`ifdef PSEUDO_PLL_PHASE_OUT_EN
      ,
      .phase_out   (phase_out)
`endif
   );

   initial forever #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   // Behavioural model: phase as a plain integer modulo 2^ACC_W, outputs one cycle behind it.
   longint m_phase = 0;
   longint m_inc   = M_INC_MIN;
   int     m_mode  = 0;            // 0 stopped, 1 running, 2 draining
   bit     m_pend  = 0;
   int     m_pend_code = 0;
   bit     e_clk = 0, e_tick = 0, e_busy = 0, e_done = 0;
   int     e_phase = 0;

   function automatic longint inc_of(input int code);
      return M_INC_MIN + longint'(code) * M_INC_STEP;
   endfunction

   task automatic model_step();
      bit     nclk, wrapped, done;
      longint total;
      if (rst_in) begin
         m_phase = 0; m_mode = 0; m_inc = inc_of(0); m_pend = 0;
         e_clk = 0; e_tick = 0; e_busy = 0; e_done = 0; e_phase = 0;
         return;
      end
      nclk    = (m_phase >= HALF);
      e_tick  = nclk && !e_clk;
      e_clk   = nclk;
      e_phase = int'(m_phase >> (ACC_W - 8));
      done    = 0;
      if (m_mode == 0) begin
         m_phase = 0;
         if (freq_load) begin
            m_inc = inc_of(int'(freq_param)); m_pend = 0; done = 1;
         end else if (m_pend) begin
            m_inc = inc_of(m_pend_code); m_pend = 0; done = 1;
         end
         if (run) m_mode = 1;
      end else begin
         total   = m_phase + m_inc;
         wrapped = (total >= MOD);
         m_phase = total % MOD;
         if (wrapped && m_pend) begin
            m_inc = inc_of(m_pend_code); m_pend = 0; done = 1;
         end
         if (freq_load) begin
            m_pend = 1; m_pend_code = int'(freq_param);
         end
         if (m_mode == 1) begin
            if (!run) m_mode = 2;
         end else if (run) begin
            m_mode = 1;
         end else if (wrapped) begin
            m_phase = 0; m_mode = 0;
         end
      end
      e_done = done;
      e_busy = m_pend;
   endtask

   initial forever begin
      @(posedge clk_in);
      model_step();
   end

   initial begin
      @(posedge clk_in);
      forever begin
         @(negedge clk_in);
         check("cmp_clk_out", longint'(clk_out), longint'(e_clk));
         check("cmp_tick", longint'(tick), longint'(e_tick));
         check("cmp_busy", longint'(freq_busy), longint'(e_busy));
         check("cmp_update_done", longint'(update_done), longint'(e_done));
`ifdef PSEUDO_PLL_PHASE_OUT_EN
         check("cmp_phase_out", longint'(phase_out), longint'(e_phase));
`endif
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n, output int ticks, output int dones);
      ticks = 0;
      dones = 0;
      repeat (n) begin
         @(negedge clk_in);
         ticks += int'(tick);
         dones += int'(update_done);
      end
   endtask

   task automatic load(input int code);
      @(negedge clk_in);
      freq_load  = 1'b1;
      freq_param = 8'(code);
      @(negedge clk_in);
      freq_load  = 1'b0;
   endtask

   // which: 0 clk_out, 1 tick, 2 update_done
   task automatic wait_sig(input string name, input int which, input bit val, input int limit);
      int  k;
      bit  cur;
      k = 0;
      forever begin
         cur = (which == 0) ? clk_out : (which == 1) ? tick : update_done;
         if (cur == val || k >= limit) break;
         @(negedge clk_in);
         k++;
      end
      check(name, longint'(cur), longint'(val));
   endtask

   int t, d, k;
   bit busy_ok, mono_ok;
`ifdef PSEUDO_PLL_PHASE_OUT_EN
   int prev_phase, falls;
   bit prev_clk;
`endif

   initial begin
      rst_in = 1'b1; run = 1'b1; freq_load = 1'b0; freq_param = 8'd0;
      repeat (3) @(negedge clk_in);
      check("rst_clk_out", longint'(clk_out), 0);
      check("rst_tick", longint'(tick), 0);
      check("rst_busy", longint'(freq_busy), 0);
      check("rst_update_done", longint'(update_done), 0);
      rst_in = 1'b0;

      // Code 0: 6 kHz -> 60 ticks in 10 ms.
      cycles(10000, t, d);
      check_range("t1_ticks_code0", t, 59, 61);
      check("t1_no_update", d, 0);

      // Code 255 while running: busy until the next wrap.
      load(255);
      check("t2_busy_after_load", longint'(freq_busy), 1);
      busy_ok = 1; k = 0;
      while (!update_done && k < 400) begin
         if (!freq_busy) busy_ok = 0;
         @(negedge clk_in);
         k++;
      end
      check("t2_done_seen", longint'(update_done), 1);
      check("t2_busy_held", longint'(busy_ok), 1);
      check("t2_busy_clear_at_done", longint'(freq_busy), 0);
      // 0.8 of a phase turn per cycle aliases to 200 kHz on the MSB.
      cycles(1000, t, d);
      check_range("t2_ticks_code255", t, 199, 201);
      check("t2_no_extra_update", d, 0);

      // Back to code 0, then two loads inside one period: one update, code 20 wins.
      load(0);
      wait_sig("t3_code0_applied", 2, 1'b1, 20);
      load(10);
      load(20);
      cycles(400, t, d);
      check("t3_single_update", d, 1);
      check("t3_busy_clear", longint'(freq_busy), 0);
      cycles(1000, t, d);
      check_range("t3_ticks_code20", t, 67, 69);

      // Stop while high: period completes, output parks low.
      wait_sig("t4_wait_high", 0, 1'b1, 40);
      run = 1'b0;
      wait_sig("t4_falls", 0, 1'b0, 40);
      cycles(30, t, d);
      check("t4_no_ticks_stopped", t, 0);
      check("t4_clk_low_stopped", longint'(clk_out), 0);
`ifdef PSEUDO_PLL_PHASE_OUT_EN
      check("t4_phase_zero_stopped", longint'(phase_out), 0);
`endif
      // Load while stopped: applied at once, never busy.
      load(5);
      check("stop_load_done", longint'(update_done), 1);
      check("stop_load_not_busy", longint'(freq_busy), 0);
      run = 1'b1;
      wait_sig("t4_resume_tick", 1, 1'b1, 60);

      // Reset with a code pending.
      load(100);
      check("t5_busy_before_rst", longint'(freq_busy), 1);
      rst_in = 1'b1;
      @(negedge clk_in);
      check("t5_clk_out", longint'(clk_out), 0);
      check("t5_busy", longint'(freq_busy), 0);
      check("t5_tick", longint'(tick), 0);
      check("t5_update_done", longint'(update_done), 0);
      rst_in = 1'b0;
      cycles(200, t, d);
      check("t5_pending_discarded", d, 0);

`ifdef PSEUDO_PLL_PHASE_OUT_EN
      // Code 0: phase_out rises monotonically and wraps as clk_out falls.
      mono_ok = 1; falls = 0;
      prev_phase = int'(phase_out); prev_clk = clk_out;
      repeat (400) begin
         @(negedge clk_in);
         if (prev_clk && !clk_out) begin
            falls++;
            check_range("t6_phase_after_wrap", longint'(phase_out), 0, 1);
            check_range("t6_phase_before_wrap", prev_phase, 254, 255);
         end else if (int'(phase_out) < prev_phase) begin
            mono_ok = 0;
         end
         prev_phase = int'(phase_out);
         prev_clk   = clk_out;
      end
      check("t6_monotonic", longint'(mono_ok), 1);
      check_range("t6_falls", falls, 2, 3);
`else
      mono_ok = 1;
      cycles(100, t, d);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
